// File: rtl/lab_pkg.sv
// Shared constants, state encoding and LFSR step for the LFSR decrypter.
package lab_pkg;

  localparam int unsigned NUM_TAPS = 6;

  localparam logic [5:0] TAP_LIST [0:NUM_TAPS-1] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  localparam logic [7:0] PRE_CHAR = 8'h5F;
  localparam logic [7:0] PAD_CHAR = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_PROBE,
    S_SELECT,
    S_DECRYPT,
    S_PAD,
    S_DONE
  } state_t;

  function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] taps);
    return {s[4:0], ^(s & taps)};
  endfunction

  function automatic logic [5:0] tap_sel(input logic [2:0] idx);
    tap_sel = '0;
    for (int unsigned j = 0; j < NUM_TAPS; j++)
      if (idx == 3'(j)) tap_sel = TAP_LIST[j];
  endfunction

endpackage

// File: rtl/lfsr6.sv
// 6-bit Fibonacci LFSR with synchronous load; load has priority over advance.
module lfsr6
  import lab_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       init,
  input  logic [5:0] taps,
  input  logic [5:0] start,
  output logic [5:0] state
);

  always_ff @(posedge clk) begin
    if (init)
      state <= start;
    else if (en)
      state <= lfsr_next(state, taps);
  end

endmodule

// File: rtl/lfsr_decrypt.sv
// Recovers LFSR seed, taps and preamble length from an encrypted dat_mem
// region, then writes the plaintext to the output region and space-pads it.
module lfsr_decrypt
  import lab_pkg::*;
#(
  parameter int unsigned MSG_LEN   = 64,
  parameter int unsigned SRC_BASE  = 64,
  parameter int unsigned DST_BASE  = 0,
  parameter int unsigned PROBE_LEN = 6,
  parameter int unsigned MAX_PRE   = 12
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  output logic [7:0] raddr,
  input  logic [7:0] data_out,
  output logic       write_en,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       done,
  output logic       err,
  output logic [5:0] taps_found,
  output logic [7:0] pre_len_found
);

  localparam logic [7:0] SRC = 8'(SRC_BASE);
  localparam logic [7:0] DST = 8'(DST_BASE);

  state_t              state;
  logic [7:0]          pad_idx;
  logic                in_msg;
  logic [2:0]          sel;
  logic [NUM_TAPS-1:0] alive;
  logic [NUM_TAPS-1:0] match;
  logic [5:0]          cand_state [NUM_TAPS];
  logic [5:0]          sel_state;
  logic [2:0]          first_hit;
  logic                any_hit;
  logic [5:0]          obs;
  logic                hdr_ok;
  logic [7:0]          k;
  logic [7:0]          plain;
  logic                is_pre;
  logic [7:0]          cur_pre;
  logic                lfsr_init;
  logic                lfsr_en;

  assign obs       = data_out[5:0] ^ 6'h1F;
  assign hdr_ok    = (data_out[7:6] == 2'b01);
  assign k         = raddr - SRC;
  assign lfsr_init = (state == S_SEED);
  assign lfsr_en   = (state == S_PROBE) || (state == S_SELECT) || (state == S_DECRYPT);

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_cand
    lfsr6 u_lfsr (
      .clk   (clk),
      .en    (lfsr_en),
      .init  (lfsr_init),
      .taps  (TAP_LIST[g]),
      .start (obs),
      .state (cand_state[g])
    );
  end

  always_comb begin
    match     = '0;
    first_hit = '0;
    any_hit   = 1'b0;
    sel_state = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      match[i] = (lfsr_next(cand_state[i], TAP_LIST[i]) == obs);
      if (alive[i] && !any_hit) begin
        first_hit = 3'(i);
        any_hit   = 1'b1;
      end
      if (sel == 3'(i)) sel_state = cand_state[i];
    end
  end

  assign plain   = data_out ^ {2'b00, sel_state};
  assign is_pre  = !in_msg && (k < 8'(MAX_PRE)) && (plain == PRE_CHAR);
  // Before the first message byte is latched, the current index is the preamble length.
  assign cur_pre = in_msg ? pre_len_found : k;

  // Write port is combinational from the registered state so each byte is
  // written in the cycle it is read, and drops as soon as reset lands.
  always_comb begin
    write_en = 1'b0;
    waddr    = '0;
    data_in  = '0;
    if (state == S_PAD) begin
      write_en = 1'b1;
      waddr    = DST + pad_idx;
      data_in  = PAD_CHAR;
    end else if (state == S_DECRYPT && !is_pre) begin
      write_en = 1'b1;
      waddr    = DST + k - cur_pre;
      data_in  = plain;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state         <= S_IDLE;
      raddr         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      taps_found    <= '0;
      pre_len_found <= '0;
      alive         <= '0;
      sel           <= '0;
      in_msg        <= 1'b0;
      pad_idx       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_SEED;
            raddr         <= SRC;
            done          <= 1'b0;
            err           <= 1'b0;
            taps_found    <= '0;
            pre_len_found <= '0;
          end
        end
        S_SEED: begin
          alive  <= '1;
          in_msg <= 1'b0;
          if (obs == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state <= S_PROBE;
            raddr <= raddr + 8'd1;
          end
        end
        S_PROBE: begin
          alive <= alive & match & {NUM_TAPS{hdr_ok}};
          raddr <= raddr + 8'd1;
          if (k == 8'(PROBE_LEN - 1)) state <= S_SELECT;
        end
        S_SELECT: begin
          if (any_hit) begin
            sel        <= first_hit;
            taps_found <= tap_sel(first_hit);
            state      <= S_DECRYPT;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        S_DECRYPT: begin
          if (!is_pre && !in_msg) begin
            in_msg        <= 1'b1;
            pre_len_found <= k;
          end
          if (k == 8'(MSG_LEN - 1)) begin
            state   <= S_PAD;
            pad_idx <= 8'(MSG_LEN) - cur_pre;
          end else begin
            raddr <= raddr + 8'd1;
          end
        end
        S_PAD: begin
          pad_idx <= pad_idx + 8'd1;
          if (pad_idx == 8'(MSG_LEN - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Bench for lfsr_decrypt: vector table plus random cases against a spec-level decode model.
module tb_lfsr_decrypt;

  localparam logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  logic       clk = 1'b0;
  logic       init_n;
  logic       start;
  logic [7:0] raddr, data_out, waddr, data_in, pre_len_found;
  logic       write_en, done, err;
  logic [5:0] taps_found;

  logic [7:0]  src_mem [64];
  logic [7:0]  dst_mem [256];
  logic        clr;
  int unsigned n_wr = 0;
  int unsigned bad_addr = 0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] msg_buf [64];
  int         msg_len;

  bit         exp_err;
  logic [5:0] exp_taps;
  int         exp_pre;
  int         exp_lat;
  logic [7:0] exp_dst [64];

  typedef struct {
    int         tap_idx;
    logic [5:0] st;
    int         pre;
    int         extra;
    logic [5:0] exp_taps;
    int         exp_pre;
    int         exp_lat;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  lfsr_decrypt dut (
    .clk           (clk),
    .init_n        (init_n),
    .start         (start),
    .raddr         (raddr),
    .data_out      (data_out),
    .write_en      (write_en),
    .waddr         (waddr),
    .data_in       (data_in),
    .done          (done),
    .err           (err),
    .taps_found    (taps_found),
    .pre_len_found (pre_len_found)
  );

  assign data_out = (raddr >= 8'd64 && raddr < 8'd128) ? src_mem[raddr[5:0]] : dst_mem[raddr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) dst_mem[i] <= 8'hAA;
    end else if (write_en) begin
      dst_mem[waddr] <= data_in;
      n_wr <= n_wr + 1;
      if (waddr >= 8'd64) bad_addr <= bad_addr + 1;
    end
  end

  function automatic logic [5:0] nxt(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], 1'($countones(s & t) % 2)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_fixed();
    string m;
    m = "Mr. Watson, come here.";
    msg_len = m.len();
    for (int i = 0; i < msg_len; i++) msg_buf[i] = m[i];
  endtask

  task automatic load_random(input int pre);
    msg_len = $urandom_range(1, 64 - pre);
    msg_buf[0] = 8'($urandom_range(33, 94));
    for (int i = 1; i < msg_len; i++) msg_buf[i] = 8'($urandom_range(32, 126));
  endtask

  task automatic encrypt(input logic [5:0] t, input logic [5:0] st, input int pre);
    logic [5:0] s;
    logic [7:0] p;
    s = st;
    for (int k = 0; k < 64; k++) begin
      if (k < pre) p = 8'h5F;
      else if (k - pre < msg_len) p = msg_buf[k - pre];
      else p = 8'h20;
      src_mem[k] = p ^ {2'b00, s};
      s = nxt(s, t);
    end
  endtask

  // Decode the encrypted region the way the block is defined to: seed from byte 0,
  // first tap candidate consistent with bytes 1..5, then strip the '_' run.
  task automatic model();
    logic [5:0] seed, s;
    logic [7:0] plain [64];
    int ch, pre;
    bit ok;
    for (int j = 0; j < 64; j++) exp_dst[j] = 8'hAA;
    exp_err = 1'b1; exp_taps = '0; exp_pre = 0;
    seed = src_mem[0][5:0] ^ 6'h1F;
    if (seed == '0) begin exp_lat = 1; return; end
    ch = -1;
    for (int i = 0; i < 6; i++) begin
      if (ch < 0) begin
        s = seed; ok = 1'b1;
        for (int k = 1; k < 6; k++) begin
          s = nxt(s, TAPS[i]);
          if (src_mem[k] != {2'b01, s ^ 6'h1F}) ok = 1'b0;
        end
        if (ok) ch = i;
      end
    end
    if (ch < 0) begin exp_lat = 7; return; end
    s = seed;
    for (int k = 0; k < 64; k++) begin
      plain[k] = src_mem[k] ^ {2'b00, s};
      s = nxt(s, TAPS[ch]);
    end
    pre = 6;
    while (pre < 12 && plain[pre] == 8'h5F) pre++;
    exp_err = 1'b0; exp_taps = TAPS[ch]; exp_pre = pre; exp_lat = 65 + pre;
    for (int j = 0; j < 64; j++) exp_dst[j] = (j < 64 - pre) ? plain[pre + j] : 8'h20;
  endtask

  task automatic run_dut(input int extra_at, output int lat, output int unsigned wr0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; wr0 = n_wr; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1; lat++;
      start = (lat == extra_at);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic verify(input string nm, input int lat, input int unsigned wr0);
    int bad, first;
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_err"}, err, exp_err);
    if (!exp_err) begin
      chk({nm, "_taps"}, taps_found, exp_taps);
      chk({nm, "_pre_len"}, pre_len_found, exp_pre);
    end
    bad = 0; first = -1;
    for (int j = 0; j < 64; j++)
      if (dst_mem[j] !== exp_dst[j]) begin bad++; if (first < 0) first = j; end
    chk({nm, $sformatf("_dst_bad_bytes(first@%0d)", first)}, bad, 0);
    chk({nm, "_writes"}, n_wr - wr0, exp_err ? 0 : 64);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, tries;
    int unsigned wr0;
    int pres [2];
    logic [5:0] sts [2];
    pres = '{7, 12};
    sts  = '{6'h01, 6'h3F};

    vecs.push_back('{0, 6'h01, 7, -1, 6'h21, 7, 72});
    for (int ti = 0; ti < 6; ti++)
      for (int pi = 0; pi < 2; pi++)
        for (int si = 0; si < 2; si++)
          vecs.push_back('{ti, sts[si], pres[pi], -1, TAPS[ti], pres[pi], 65 + pres[pi]});
    vecs.push_back('{0, 6'h01, 7, 3, 6'h21, 7, 72});

    start = 1'b0; clr = 1'b0; init_n = 1'b1;
    for (int i = 0; i < 64; i++) src_mem[i] = 8'h00;
    #2 init_n = 1'b0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_raddr", raddr, 8'h00);
    chk("rst_waddr", waddr, 8'h00);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_taps", taps_found, 6'h00);
    chk("rst_pre_len", pre_len_found, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) init_n = 1'b1;

    foreach (vecs[i]) begin
      load_fixed();
      encrypt(TAPS[vecs[i].tap_idx], vecs[i].st, vecs[i].pre);
      model();
      run_dut(vecs[i].extra, lat, wr0);
      verify($sformatf("vec%0d", i), lat, wr0);
      chk($sformatf("vec%0d_tbl_taps", i), taps_found, vecs[i].exp_taps);
      chk($sformatf("vec%0d_tbl_pre", i), pre_len_found, vecs[i].exp_pre);
      chk($sformatf("vec%0d_tbl_lat", i), lat, vecs[i].exp_lat);
    end

    for (int r = 0; r < 8; r++) begin
      int ti, pre;
      logic [5:0] st;
      ti  = $urandom_range(0, 5);
      st  = 6'($urandom_range(1, 63));
      pre = $urandom_range(6, 12);
      load_random(pre);
      encrypt(TAPS[ti], st, pre);
      model();
      run_dut(-1, lat, wr0);
      verify($sformatf("rand%0d", r), lat, wr0);
    end

    load_fixed();
    encrypt(TAPS[0], 6'h01, 7);
    src_mem[0] = 8'h5F;
    model();
    run_dut(-1, lat, wr0);
    verify("seed_zero", lat, wr0);

    load_fixed();
    tries = 0;
    do begin
      encrypt(TAPS[2], 6'h15, 8);
      for (int k = 1; k < 6; k++) src_mem[k] = 8'($urandom);
      model();
      tries++;
    end while (!exp_err && tries < 100);
    chk("nomatch_model_err", exp_err, 1'b1);
    run_dut(-1, lat, wr0);
    verify("no_match", lat, wr0);

    load_fixed();
    encrypt(TAPS[0], 6'h01, 7);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("midrst_wr_active", write_en, 1'b1);
    #2 init_n = 1'b0;
    #1;
    chk("midrst_write_en", write_en, 1'b0);
    chk("midrst_done", done, 1'b0);
    wr0 = n_wr;
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_writes", n_wr - wr0, 0);
    @(negedge clk) init_n = 1'b1;
    model();
    run_dut(-1, lat, wr0);
    verify("after_rst", lat, wr0);

    chk("waddr_in_range", bad_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
